ec_scalar_mult_ctrl: RTL

- Sequencer for secp256k1 scalar multiplication Q = k·P using MSB-first double-and-add.
- Owns the accumulator point and the scalar bit scan.
- Issues point-double and point-add operations to one shared external point-arithmetic unit over a req/ack/done handshake.
- Sits between the ECDSA sign/verify control and the point-arithmetic datapath; uses curve_point_t from elliptic_curve_structs.

---
 rtl/elliptic_curve_structs.sv | 29 ++
 rtl/ec_scalar_mult_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/elliptic_curve_structs.sv
// elliptic_curve_structs: shared secp256k1 point type plus scalar-multiplication controller types.
//   curve_point_t    : affine point {x, y}, 256 bits each
//   ec_smul_state_t  : double-and-add sequencer states
//   point_op_req_t   : one request to the point-arithmetic unit
package elliptic_curve_structs;

    typedef struct packed {
        logic [255:0] x;
        logic [255:0] y;
    } curve_point_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        NEXT,
        DBL,
        DBL_W,
        ADD,
        ADD_W,
        DONE
    } ec_smul_state_t;

    typedef struct packed {
        logic         is_add;
        curve_point_t a;
        curve_point_t b;
    } point_op_req_t;

endpackage

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: MSB-first double-and-add sequencer computing Q = k*P on an external point unit.
//   clk, rst (async, active-high)
//   start, k, p_in                 : operation launch, sampled only when idle
//   busy, done, result, result_inf : status and final point
//   op_req/op_is_add/op_a/op_b     : request to the point unit, held until op_ack
//   op_ack, op_done, op_result(_inf): point unit handshake and returned point
module ec_scalar_mult_ctrl
    import elliptic_curve_structs::*;
#(
    parameter int KW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  curve_point_t  p_in,
    output logic          busy,
    output logic          done,
    output curve_point_t  result,
    output logic          result_inf,
    output logic          op_req,
    output logic          op_is_add,
    output curve_point_t  op_a,
    output curve_point_t  op_b,
    input  logic          op_ack,
    input  logic          op_done,
    input  curve_point_t  op_result,
    input  logic          op_result_inf
);

    localparam int CW = $clog2(KW);

    ec_smul_state_t state_q, state_d;
    logic [KW-1:0]  ks_q, ks_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    curve_point_t   q_q, q_d, preg_q, preg_d, res_q, res_d;
    logic           qinf_q, qinf_d, res_inf_q, res_inf_d;
    point_op_req_t  op;

    // A request is only raised when the accumulator is finite; doubling or
    // adding to infinity is resolved locally without the point unit.
    assign op_req     = (state_q == DBL || state_q == ADD) && !qinf_q;
    assign op         = '{is_add: (state_q == ADD) && !qinf_q, a: q_q, b: preg_q};
    assign op_is_add  = op.is_add;
    assign op_a       = op.a;
    assign op_b       = op.b;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign result     = res_q;
    assign result_inf = res_inf_q;

    always_comb begin
        state_d   = state_q;
        ks_d      = ks_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        qinf_d    = qinf_q;
        preg_d    = preg_q;
        res_d     = res_q;
        res_inf_d = res_inf_q;
        case (state_q)
            IDLE: if (start) begin
                ks_d    = k;
                preg_d  = p_in;
                cnt_d   = CW'(KW - 1);
                q_d     = '0;
                qinf_d  = 1'b1;
                state_d = SCAN;
            end
            SCAN: if (ks_q[KW-1]) begin
                q_d     = preg_q;
                qinf_d  = 1'b0;
                state_d = NEXT;
            end else if (cnt_q == '0) begin
                state_d = DONE;
            end else begin
                ks_d  = ks_q << 1;
                cnt_d = cnt_q - CW'(1);
            end
            NEXT: if (cnt_q == '0) begin
                state_d = DONE;
            end else begin
                ks_d    = ks_q << 1;
                cnt_d   = cnt_q - CW'(1);
                state_d = DBL;
            end
            DBL: if (qinf_q) state_d = ks_q[KW-1] ? ADD : NEXT;
                 else if (op_ack) state_d = DBL_W;
            DBL_W: if (op_done) begin
                q_d     = op_result;
                qinf_d  = op_result_inf;
                state_d = ks_q[KW-1] ? ADD : NEXT;
            end
            ADD: if (qinf_q) begin
                q_d     = preg_q;
                qinf_d  = 1'b0;
                state_d = NEXT;
            end else if (op_ack) begin
                state_d = ADD_W;
            end
            ADD_W: if (op_done) begin
                q_d     = op_result;
                qinf_d  = op_result_inf;
                state_d = NEXT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Latch the answer on entry to DONE so it is valid during the done pulse.
        if (state_d == DONE && state_q != DONE) begin
            res_d     = q_q;
            res_inf_d = qinf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ks_q      <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            qinf_q    <= 1'b1;
            preg_q    <= '0;
            res_q     <= '0;
            res_inf_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ks_q      <= ks_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            qinf_q    <= qinf_d;
            preg_q    <= preg_d;
            res_q     <= res_d;
            res_inf_q <= res_inf_d;
        end
    end

endmodule
